imem_sync: RTL



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_fetch_pipe.sv | 74 +++++++
 rtl/imem_sync.sv | 108 ++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the clocked instruction memory: fill word, FSM encoding and
// the fetch-latency legality check.
package imem_pkg;

    localparam logic [31:0] NOP_WORD = 32'hE1A0_0000;  // MOV R0,R0

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    function automatic bit latency_ok(input int unsigned latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/imem_fetch_pipe.sv
// Fetch path: fault decode, same-cycle load bypass and a LATENCY-deep result pipeline
// whose last stage holds its data/fault while no result is valid.
module imem_fetch_pipe #(
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_accept,
    input  logic [31:0]       fetch_addr,
    output logic [ADDR_W-1:0] fetch_idx,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_fault
);

    logic              fault;
    logic              valid_in [LATENCY];
    logic [DATA_W-1:0] data_in  [LATENCY];
    logic              fault_in [LATENCY];
    logic              valid_q  [LATENCY];
    logic [DATA_W-1:0] data_q   [LATENCY];
    logic              fault_q  [LATENCY];

    assign fetch_idx = fetch_addr[ADDR_W+1:2];
    assign fault     = (|fetch_addr[1:0]) | (|fetch_addr[31:ADDR_W+2]);

    always_comb begin
        valid_in[0] = fetch_accept;
        fault_in[0] = fault;
        if (fault) begin
            data_in[0] = NOP_WORD;
        end else if (load_we && (load_addr == fetch_idx)) begin
            data_in[0] = load_data;  // write-first bypass, captured at acceptance
        end else begin
            data_in[0] = mem_rdata;
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_in[i] = valid_q[i-1];
            data_in[i]  = data_q[i-1];
            fault_in[i] = fault_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= NOP_WORD;
                fault_q[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                valid_q[i] <= valid_in[i];
                // Output stage only updates on a real result so rd_data/rd_fault hold.
                if (valid_in[i] || (i != LATENCY - 1)) begin
                    data_q[i]  <= data_in[i];
                    fault_q[i] <= fault_in[i];
                end
            end
        end
    end

    assign rd_valid = valid_q[LATENCY-1];
    assign rd_data  = data_q[LATENCY-1];
    assign rd_fault = fault_q[LATENCY-1];

endmodule

// File: rtl/imem_sync.sv
// Writable instruction memory: NOP fill after reset, load port for the program and a
// request/valid fetch port with fixed 1- or 2-cycle latency.
module imem_sync #(
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              init_busy
);
    import imem_pkg::*;

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if (!latency_ok(LATENCY)) begin : gen_bad_latency
        $error("imem_sync: LATENCY must be 1 or 2");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] fetch_idx;
    logic              load_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    assign fetch_ready = (state_q == StRun);
    assign init_busy   = (state_q == StInit);
    assign load_we     = fetch_ready & load_en;

    // Single write port shared by the NOP fill and the load port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = NOP_WORD;
        if (!reset) begin
            unique case (state_q)
                StInit: mem_we = 1'b1;
                StRun: begin
                    mem_we    = load_en;
                    mem_waddr = load_addr;
                    mem_wdata = load_data;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    imem_fetch_pipe #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY),
        .NOP_WORD(NOP_WORD)
    ) u_fetch_pipe (
        .clk         (clk),
        .reset       (reset),
        .fetch_accept(fetch_req & fetch_ready),
        .fetch_addr  (fetch_addr),
        .fetch_idx   (fetch_idx),
        .mem_rdata   (mem_q[fetch_idx]),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_fault    (rd_fault)
    );

endmodule
